// File: rtl/uart_tx_queue_if.sv
// Host/transmitter-side bundle for the UART transmit queue.
// The master modport belongs to the side that writes bytes and reports frame completion.
interface uart_tx_queue_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 3
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              clr_ovf;
  logic              done_t;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic              full;
  logic              empty;
  logic [AW:0]       count;
  logic              overflow;

  modport master (
    output wr_en, wr_data, clr_ovf, done_t,
    input  tx_start, tx_data, tx_busy, full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf, done_t,
    output tx_start, tx_data, tx_busy, full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter: launches one byte per start pulse and
// waits for the transmitter's done pulse before launching the next.
module uart_tx_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_queue_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              tx_start_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              overflow_q;
  logic              pop;
  logic              push;
  logic              drop;
  logic              is_full;

  assign is_full = (count == FULL_CNT);
  // A write into a full queue still fits when the same edge pops a byte out.
  assign push    = bus.wr_en && (!is_full || pop);
  assign drop    = bus.wr_en && is_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          next_state = S_LAUNCH;
        end
      end
      S_LAUNCH: next_state = S_WAIT;
      S_WAIT: begin
        if (bus.done_t) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      tx_start_q <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        tx_data_q <= mem[rd_ptr];
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      // Set has priority so a drop on the clearing edge is never lost.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_busy  = (state != S_IDLE);
  assign bus.full     = is_full;
  assign bus.empty    = (count == '0);
  assign bus.count    = count;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: a monitor checks every launched byte
// against a queue of expected bytes filled as stimulus is issued.
module tb_uart_tx_queue;

  logic clk;
  logic rst;

  uart_tx_queue_if #(.DATA_W(8), .AW(3)) bus ();

  uart_tx_queue #(.DATA_W(8), .DEPTH(8), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         total;
  int         bad;
  logic [7:0] exp_q[$];
  logic       prev_start;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Drives one cycle of inputs from a falling edge and returns at the next falling edge.
  task automatic apply_stimulus(input logic we, input logic [7:0] d, input logic dn, input logic clr);
    bus.wr_en   = we;
    bus.wr_data = d;
    bus.done_t  = dn;
    bus.clr_ovf = clr;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic write_byte(input logic [7:0] d);
    exp_q.push_back(d);
    apply_stimulus(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic finish_frame(input int gap, input logic expect_next);
    idle_cycles(gap);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("busy_after_done", bus.tx_busy, 0);
    idle_cycles(1);
    check_output("launch_after_idle", bus.tx_start, expect_next);
    check_output("busy_after_relaunch", bus.tx_busy, expect_next);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_tx_start"}, bus.tx_start, 0);
    check_output({tag, "_tx_data"},  bus.tx_data,  0);
    check_output({tag, "_tx_busy"},  bus.tx_busy,  0);
    check_output({tag, "_full"},     bus.full,     0);
    check_output({tag, "_empty"},    bus.empty,    1);
    check_output({tag, "_count"},    bus.count,    0);
    check_output({tag, "_overflow"}, bus.overflow, 0);
  endtask

  // Every launch must be a single-cycle pulse carrying the oldest expected byte.
  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
    end else begin
      if (bus.tx_start) begin
        check_output("start_width", prev_start, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_launch: got tx_start with data %0h, expected no launch", bus.tx_data);
        end else begin
          check_output("tx_data_order", bus.tx_data, exp_q.pop_front());
        end
      end
      prev_start = bus.tx_start;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total       = 0;
    bad         = 0;
    prev_start  = 1'b0;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.done_t  = 1'b0;
    bus.clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    $display("[TB] single byte");
    write_byte(8'h95);
    check_output("count_after_write", bus.count, 1);
    check_output("no_start_yet", bus.tx_start, 0);
    idle_cycles(1);
    check_output("start_two_edges", bus.tx_start, 1);
    check_output("count_after_pop", bus.count, 0);
    check_output("busy_on_launch", bus.tx_busy, 1);
    idle_cycles(1);
    check_output("start_cleared", bus.tx_start, 0);
    check_output("tx_data_held", bus.tx_data, 8'h95);
    idle_cycles(3);
    check_output("busy_in_wait", bus.tx_busy, 1);
    finish_frame(0, 1'b0);
    check_output("empty_after_single", bus.empty, 1);

    $display("[TB] ordering");
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    check_output("count_ordering", bus.count, 2);
    finish_frame(8, 1'b1);
    finish_frame(9, 1'b1);
    finish_frame(9, 1'b0);
    check_output("empty_after_ordering", bus.empty, 1);

    $display("[TB] fill and overflow");
    for (int i = 1; i <= 9; i++) write_byte(8'(i));
    check_output("count_full", bus.count, 8);
    check_output("full_flag", bus.full, 1);
    check_output("no_overflow_yet", bus.overflow, 0);
    apply_stimulus(1'b1, 8'h0A, 1'b0, 1'b0);
    check_output("overflow_set", bus.overflow, 1);
    check_output("count_after_drop", bus.count, 8);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("overflow_cleared", bus.overflow, 0);
    apply_stimulus(1'b1, 8'h0B, 1'b0, 1'b1);
    check_output("overflow_set_wins", bus.overflow, 1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("overflow_cleared_again", bus.overflow, 0);

    $display("[TB] push and pop at full");
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("idle_full_busy", bus.tx_busy, 0);
    check_output("idle_full_count", bus.count, 8);
    exp_q.push_back(8'hAB);
    apply_stimulus(1'b1, 8'hAB, 1'b0, 1'b0);
    check_output("pushpop_start", bus.tx_start, 1);
    check_output("pushpop_count", bus.count, 8);
    check_output("pushpop_overflow", bus.overflow, 0);
    for (int i = 0; i < 8; i++) finish_frame(4, 1'b1);
    finish_frame(4, 1'b0);
    check_output("empty_after_drain", bus.empty, 1);

    $display("[TB] spurious done and reset mid-frame");
    write_byte(8'hC3);
    idle_cycles(1);
    check_output("spurious_launch", bus.tx_start, 1);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("done_in_launch_ignored", bus.tx_busy, 1);
    idle_cycles(3);
    check_output("still_waiting", bus.tx_busy, 1);
    finish_frame(0, 1'b0);

    write_byte(8'h44);
    write_byte(8'h55);
    write_byte(8'h66);
    write_byte(8'h77);
    idle_cycles(2);
    check_output("queued_before_reset", bus.count, 3);
    check_output("busy_before_reset", bus.tx_busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(10);
    check_output("no_launch_after_reset", bus.tx_busy, 0);
    write_byte(8'h5A);
    idle_cycles(1);
    check_output("launch_after_reset", bus.tx_start, 1);
    finish_frame(2, 1'b0);

    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
